// File: rtl/ctrl_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes and immediate-extender modes.
package ctrl_unit_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ALU_REG = 2'b00,
        BRANCH  = 2'b01,
        LDST    = 2'b10,
        ALU_IMM = 2'b11
    } iclass_t;

    localparam logic [1:0] EXT_SIGN  = 2'b11;
    localparam logic [1:0] EXT_UPPER = 2'b00;

    // Immediate extender, keyed on the same ext_mode codes the FSM produces.
    function automatic logic [31:0] ext_imm(input logic [1:0] mode, input logic [15:0] imm);
        ext_imm = (mode == EXT_UPPER) ? {imm, 16'h0000} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ctrl_unit_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the timeout count.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == W'(MEM_TIMEOUT));

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle processor control FSM: fetch/decode/exec/mem/wb sequencing,
// memory-timeout fault and retired-instruction counter.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  instr_class,
    input  logic        instr_sub,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ext_mode,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        reg_write,
    output logic        wb_mem,
    output logic        alu_src_imm,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] retire_cnt
);
    state_t  state_q, next_s;
    iclass_t cls;
    logic    in_wait, expired, retire;

    assign cls     = iclass_t'(instr_class);
    assign state   = state_q;
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);

    // Outside FETCH/MEM the counter is held clear, so each wait starts from zero.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (mem_ready || !in_wait),
        .enable  (in_wait && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            ext_mode   <= EXT_SIGN;
            fault      <= 1'b0;
            retire_cnt <= 16'h0000;
        end else begin
            state_q <= next_s;
            if (next_s == S_FAULT)
                fault <= 1'b1;
            if (state_q == S_DECODE)
                ext_mode <= (cls == ALU_IMM && instr_sub) ? EXT_UPPER : EXT_SIGN;
            if (retire)
                retire_cnt <= retire_cnt + 16'd1;
        end
    end

    always_comb begin
        next_s = S_FETCH;
        case (state_q)
            S_FETCH:  next_s = mem_ready ? S_DECODE : (expired ? S_FAULT : S_FETCH);
            S_DECODE: next_s = S_EXEC;
            S_EXEC: begin
                case (cls)
                    BRANCH:  next_s = S_FETCH;
                    LDST:    next_s = S_MEM;
                    default: next_s = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    next_s = instr_sub ? S_FETCH : S_WB;
                else
                    next_s = expired ? S_FAULT : S_MEM;
            end
            S_WB:    next_s = S_FETCH;
            S_FAULT: next_s = S_FAULT;
            default: next_s = S_FETCH;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_branch   = 1'b0;
        reg_write   = 1'b0;
        wb_mem      = 1'b0;
        alu_src_imm = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                alu_src_imm = (cls == LDST) || (cls == ALU_IMM);
                if (cls == BRANCH) begin
                    pc_write  = zero;
                    pc_branch = zero;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                mem_read  = !instr_sub;
                mem_write = instr_sub;
                retire    = instr_sub && mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_mem    = (cls == LDST) && !instr_sub;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Randomized scoreboard bench for ctrl_unit: per-instruction expected profiles
// are queued by the driver and checked by a monitor at each retirement.
module tb_ctrl_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  instr_class;
    logic        instr_sub, zero, mem_ready;
    logic [1:0]  ext_mode;
    logic        mem_read, mem_write, ir_write, pc_write, pc_branch;
    logic        reg_write, wb_mem, alu_src_imm, fault;
    logic [2:0]  state;
    logic [15:0] retire_cnt;

    ctrl_unit #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .instr_class(instr_class),
        .instr_sub(instr_sub), .zero(zero), .mem_ready(mem_ready),
        .ext_mode(ext_mode), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
        .reg_write(reg_write), .wb_mem(wb_mem), .alu_src_imm(alu_src_imm),
        .fault(fault), .state(state), .retire_cnt(retire_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cycles; int rd; int wr; int rw; int wbm;
        int pcw; int pcb; int irw; int alu; int ext; int rc;
    } prof_t;

    prof_t sbq[$];
    int    n_cmp = 0, n_bad = 0;
    int    ref_cnt = 0;
    int    resync_req = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: accumulate strobe activity per cycle, compare on each retirement.
    prof_t acc;
    int    resync_ack = 0;
    logic [15:0] prev_rc = 16'h0;
    always begin
        prof_t e;
        @(negedge clock);
        #1;
        if (!reset_n) begin
            acc     = '{default: 0};
            prev_rc = 16'h0;
        end else begin
            if (retire_cnt != prev_rc) begin
                prev_rc = retire_cnt;
                if (resync_ack != resync_req) begin
                    resync_ack = resync_req;
                end else begin
                    if (sbq.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("cycles",      acc.cycles, e.cycles);
                        check("mem_read",    acc.rd,     e.rd);
                        check("mem_write",   acc.wr,     e.wr);
                        check("reg_write",   acc.rw,     e.rw);
                        check("wb_mem",      acc.wbm,    e.wbm);
                        check("pc_write",    acc.pcw,    e.pcw);
                        check("pc_branch",   acc.pcb,    e.pcb);
                        check("ir_write",    acc.irw,    e.irw);
                        check("alu_src_imm", acc.alu,    e.alu);
                        check("ext_mode",    int'(ext_mode),   e.ext);
                        check("retire_cnt",  int'(retire_cnt), e.rc);
                    end
                    acc = '{default: 0};
                end
            end
            acc.cycles++;
            acc.rd  += int'(mem_read);
            acc.wr  += int'(mem_write);
            acc.rw  += int'(reg_write);
            acc.wbm += int'(wb_mem);
            acc.pcw += int'(pc_write);
            acc.pcb += int'(pc_branch);
            acc.irw += int'(ir_write);
            acc.alu += int'(alu_src_imm);
        end
    end

    // Wait (bounded) for a memory strobe, injecting ready noise where it must be ignored.
    task automatic wait_strobe();
        for (int i = 0; i < 40; i++) begin
            if (mem_read || mem_write) return;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        mem_ready = 1'b0;
        check("strobe_timeout", 0, 1);
    endtask

    task automatic serve(input int d);
        for (int i = 0; i < d; i++) begin
            mem_ready = 1'b0;
            @(negedge clock);
        end
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
    endtask

    // Reference profile: cycle and strobe counts follow from class rules alone.
    task automatic run_instr(input int cls, input int sub, input int z, input int fd, input int md);
        prof_t e;
        bit ld = (cls == 2) && (sub == 0);
        bit st = (cls == 2) && (sub == 1);
        bit br = (cls == 1);
        e.cycles = (fd + 1) + 2 + ((cls == 2) ? md + 1 : 0) + ((br || st) ? 0 : 1);
        e.rd  = (fd + 1) + (ld ? md + 1 : 0);
        e.wr  = st ? md + 1 : 0;
        e.rw  = (br || st) ? 0 : 1;
        e.wbm = ld ? 1 : 0;
        e.pcb = (br && z == 1) ? 1 : 0;
        e.pcw = 1 + e.pcb;
        e.irw = 1;
        e.alu = (cls == 2 || cls == 3) ? 1 : 0;
        e.ext = (cls == 3 && sub == 1) ? 0 : 3;
        ref_cnt = (ref_cnt + 1) % 65536;
        e.rc  = ref_cnt;
        sbq.push_back(e);
        instr_class = 2'(cls);
        instr_sub   = 1'(sub);
        zero        = 1'(z);
        wait_strobe();
        serve(fd);
        if (cls == 2) begin
            wait_strobe();
            serve(md);
        end
        wait_strobe();
    endtask

    initial begin
        reset_n = 1'b0; instr_class = 2'b00; instr_sub = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_state",      int'(state),      0);
        check("rst_ext_mode",   int'(ext_mode),   3);
        check("rst_fault",      int'(fault),      0);
        check("rst_retire_cnt", int'(retire_cnt), 0);
        check("rst_mem_read",   int'(mem_read),   1);
        reset_n = 1'b1;

        run_instr(3, 0, 0, 0, 0);   // addi
        run_instr(3, 1, 0, 2, 0);   // lui
        run_instr(2, 0, 0, 0, 3);   // load, ready after 3 MEM waits
        run_instr(2, 1, 0, 1, 2);   // store
        run_instr(1, 0, 1, 0, 0);   // branch taken
        run_instr(1, 0, 0, 0, 0);   // branch not taken
        run_instr(0, 0, 0, 15, 0);  // fetch ready exactly at timeout count
        run_instr(2, 0, 0, 0, 15);  // load ready exactly at timeout count
        run_instr(2, 1, 1, 4, 15);  // store ready exactly at timeout count

        for (int k = 0; k < 60; k++) begin
            int fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            run_instr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                      fd, $urandom_range(0, 15));
        end
        run_instr(3, 1, 0, 0, 0);   // leave ext_mode at upper before the fault reset

        // Fetch timeout: 16 FETCH cycles, then FAULT until reset.
        mem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (i == 15) begin
                check("pre_timeout_state", int'(state), 0);
                check("pre_timeout_fault", int'(fault), 0);
            end
        end
        check("timeout_state",    int'(state),    7);
        check("timeout_fault",    int'(fault),    1);
        check("timeout_mem_read", int'(mem_read), 0);
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        check("fault_sticky_state", int'(state), 7);
        check("fault_sticky_flag",  int'(fault), 1);
        check("fault_strobes", int'(mem_read) + int'(mem_write) + int'(ir_write) + int'(pc_write)
              + int'(reg_write) + int'(alu_src_imm), 0);
        check("fault_retire_hold", int'(retire_cnt), ref_cnt);
        mem_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        check("fault_rst_state",    int'(state),      0);
        check("fault_rst_fault",    int'(fault),      0);
        check("fault_rst_ext_mode", int'(ext_mode),   3);
        check("fault_rst_retire",   int'(retire_cnt), 0);
        ref_cnt = 0;
        reset_n = 1'b1;

        run_instr(0, 1, 1, 1, 0);

        // Reset in the middle of a store's memory wait.
        instr_class = 2'b10; instr_sub = 1'b1; zero = 1'b0;
        wait_strobe();
        serve(0);
        wait_strobe();
        check("store_mem_write", int'(mem_write), 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midstore_rst_state",     int'(state),      0);
        check("midstore_rst_mem_write", int'(mem_write),  0);
        check("midstore_rst_mem_read",  int'(mem_read),   1);
        check("midstore_rst_retire",    int'(retire_cnt), 0);

        // Preload the counter near its top to exercise the FFFF->0000 wrap.
        resync_req++;
        force dut.retire_cnt = 16'hFFFD;
        ref_cnt = 16'hFFFD;
        reset_n = 1'b1;
        fork
            begin
                @(posedge clock);
                #1;
                release dut.retire_cnt;
            end
        join_none
        run_instr(1, 0, 0, 1, 0);
        run_instr(3, 0, 0, 0, 0);
        run_instr(2, 1, 0, 0, 1);
        run_instr(2, 0, 0, 2, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
